// File: rtl/alarm_set_ctrl.sv
// Alarm time registers (BCD HH:MM), button editing, match detection and ring FSM.
// Optional snooze behaviour is compiled in when ALARM_SNOOZE_EN is defined.
module alarm_set_ctrl #(
  parameter int RING_SECS   = 60,
  parameter int SNOOZE_SECS = 300,
  parameter int CNT_W       = 9
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick_1hz,
  input  logic       set_mode,
  input  logic       btn_min,
  input  logic       btn_hour,
  input  logic       alarm_en,
  input  logic       stop,
  input  logic [3:0] a0,
  input  logic [3:0] a1,
  input  logic [3:0] a2,
  input  logic [3:0] a3,
  output logic [3:0] b0,
  output logic [3:0] b1,
  output logic [3:0] b2,
  output logic [3:0] b3,
  output logic       ring
);

`ifdef ALARM_SNOOZE_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1, SNOOZE = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RINGING = 2'd1} state_t;
  localparam int snooze_secs_unused = SNOOZE_SECS;
`endif

  logic             btn_min_q, btn_hour_q, stop_q;
  logic             min_pulse, hour_pulse, stop_pulse;
  logic [3:0]       b0_q, b1_q, b2_q, b3_q;
  logic [3:0]       b0_d, b1_d, b2_d, b3_d;
  logic             match, match_q, trigger;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ring_q, ring_d;
  logic             abort, ring_timeout;

  assign min_pulse  = btn_min  & ~btn_min_q;
  assign hour_pulse = btn_hour & ~btn_hour_q;
  assign stop_pulse = stop     & ~stop_q;

  assign match   = alarm_en & ~set_mode &
                   ({a3, a2, a1, a0} == {b3_q, b2_q, b1_q, b0_q});
  assign trigger = match & ~match_q;

  // Minute and hour fields are edited independently; minute wrap never carries.
  always_comb begin
    b0_d = b0_q;
    b1_d = b1_q;
    b2_d = b2_q;
    b3_d = b3_q;
    if (set_mode) begin
      if (min_pulse) begin
        if (b0_q == 4'd9) begin
          b0_d = 4'd0;
          b1_d = (b1_q == 4'd5) ? 4'd0 : b1_q + 4'd1;
        end else begin
          b0_d = b0_q + 4'd1;
        end
      end
      if (hour_pulse) begin
        if (b3_q == 4'd2 && b2_q == 4'd3) begin
          b3_d = 4'd0;
          b2_d = 4'd0;
        end else if (b2_q == 4'd9) begin
          b3_d = b3_q + 4'd1;
          b2_d = 4'd0;
        end else begin
          b2_d = b2_q + 4'd1;
        end
      end
    end
  end

  assign abort        = set_mode | ~alarm_en | stop_pulse;
  assign ring_timeout = tick_1hz && (cnt_q == CNT_W'(RING_SECS - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (trigger) state_d = RINGING;
      end
      RINGING: begin
        if (abort)             state_d = IDLE;
        else if (ring_timeout) state_d = IDLE;
`ifdef ALARM_SNOOZE_EN
        else if (min_pulse)    state_d = SNOOZE;
`endif
      end
`ifdef ALARM_SNOOZE_EN
      SNOOZE: begin
        if (abort) state_d = IDLE;
        else if (tick_1hz && (cnt_q == CNT_W'(SNOOZE_SECS - 1))) state_d = RINGING;
      end
`endif
      default: state_d = IDLE;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q)                cnt_d = '0;
    else if (tick_1hz && state_q != IDLE)  cnt_d = cnt_q + 1'b1;

    ring_d = (state_d == RINGING);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      btn_min_q  <= 1'b0;
      btn_hour_q <= 1'b0;
      stop_q     <= 1'b0;
      b0_q       <= 4'd0;
      b1_q       <= 4'd0;
      b2_q       <= 4'd0;
      b3_q       <= 4'd0;
      match_q    <= 1'b0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      ring_q     <= 1'b0;
    end else begin
      btn_min_q  <= btn_min;
      btn_hour_q <= btn_hour;
      stop_q     <= stop;
      b0_q       <= b0_d;
      b1_q       <= b1_d;
      b2_q       <= b2_d;
      b3_q       <= b3_d;
      match_q    <= match;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ring_q     <= ring_d;
    end
  end

  assign b0   = b0_q;
  assign b1   = b1_q;
  assign b2   = b2_q;
  assign b3   = b3_q;
  assign ring = ring_q;

endmodule

// File: tb/tb_alarm_set_ctrl.sv
// Directed bench for alarm_set_ctrl: vector table for single-cycle edits plus
// hand-written sequences for wrap, ring, timeout, abort, snooze and reset.
module tb_alarm_set_ctrl;

  logic        clk, rst_n, tick_1hz, set_mode, btn_min, btn_hour, alarm_en, stop;
  logic [15:0] a_v;
  logic [3:0]  b0, b1, b2, b3;
  logic        ring;
  wire  [15:0] b_v = {b3, b2, b1, b0};

  int n_tests = 0;
  int n_fail  = 0;

  alarm_set_ctrl #(.RING_SECS(3), .SNOOZE_SECS(2), .CNT_W(9)) dut (
    .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .set_mode(set_mode),
    .btn_min(btn_min), .btn_hour(btn_hour), .alarm_en(alarm_en), .stop(stop),
    .a0(a_v[3:0]), .a1(a_v[7:4]), .a2(a_v[11:8]), .a3(a_v[15:12]),
    .b0(b0), .b1(b1), .b2(b2), .b3(b3), .ring(ring)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string       name;
    logic        sm, bm, bh, en, st;
    logic [15:0] a;
    logic [15:0] exp_b;
    logic        exp_ring;
  } vec_t;

  vec_t vecs[11];

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic press_min(input int n);
    for (int i = 0; i < n; i++) begin
      btn_min = 1'b1; step();
      btn_min = 1'b0; step();
    end
  endtask

  task automatic press_hour(input int n);
    for (int i = 0; i < n; i++) begin
      btn_hour = 1'b1; step();
      btn_hour = 1'b0; step();
    end
  endtask

  task automatic pulse_tick();
    tick_1hz = 1'b1; step();
    tick_1hz = 1'b0; step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    step();
  endtask

  // leave and re-enter normal mode so an equal time produces a fresh trigger
  task automatic retrigger();
    set_mode = 1'b1; step();
    set_mode = 1'b0; step();
  endtask

  initial begin
    rst_n = 1'b0; tick_1hz = 1'b0; set_mode = 1'b0; btn_min = 1'b0;
    btn_hour = 1'b0; alarm_en = 1'b0; stop = 1'b0; a_v = 16'h0000;

    vecs[0]  = '{"min_press",     1, 1, 0, 0, 0, 16'h1200, 16'h0001, 0};
    vecs[1]  = '{"min_held",      1, 1, 0, 0, 0, 16'h1200, 16'h0001, 0};
    vecs[2]  = '{"min_release",   1, 0, 0, 0, 0, 16'h1200, 16'h0001, 0};
    vecs[3]  = '{"hour_press",    1, 0, 1, 0, 0, 16'h1200, 16'h0101, 0};
    vecs[4]  = '{"hour_release",  1, 0, 0, 0, 0, 16'h1200, 16'h0101, 0};
    vecs[5]  = '{"both_press",    1, 1, 1, 0, 0, 16'h1200, 16'h0202, 0};
    vecs[6]  = '{"both_release",  1, 0, 0, 0, 0, 16'h1200, 16'h0202, 0};
    vecs[7]  = '{"min_no_edit",   0, 1, 0, 0, 0, 16'h1200, 16'h0202, 0};
    vecs[8]  = '{"min_rel_norm",  0, 0, 0, 0, 0, 16'h1200, 16'h0202, 0};
    vecs[9]  = '{"hour_no_edit",  0, 0, 1, 0, 0, 16'h1200, 16'h0202, 0};
    vecs[10] = '{"hour_rel_norm", 0, 0, 0, 0, 0, 16'h1200, 16'h0202, 0};

    #3;
    chk("reset_b", b_v, 16'h0000);
    chk("reset_ring", {15'd0, ring}, 16'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 11; i++) begin
      set_mode = vecs[i].sm; btn_min = vecs[i].bm; btn_hour = vecs[i].bh;
      alarm_en = vecs[i].en; stop = vecs[i].st; a_v = vecs[i].a;
      step();
      chk({vecs[i].name, "_b"}, b_v, vecs[i].exp_b);
      chk({vecs[i].name, "_ring"}, {15'd0, ring}, {15'd0, vecs[i].exp_ring});
    end

    // minute and hour wrap
    do_reset();
    set_mode = 1'b1;
    press_min(59);  chk("min_59", b_v, 16'h0059);
    press_min(1);   chk("min_wrap", b_v, 16'h0000);
    press_hour(9);  chk("hour_09", b_v, 16'h0900);
    press_hour(1);  chk("hour_10", b_v, 16'h1000);
    press_hour(13); chk("hour_23", b_v, 16'h2300);
    press_hour(1);  chk("hour_wrap", b_v, 16'h0000);
    press_hour(5); press_min(59);
    chk("set_0559", b_v, 16'h0559);
    press_min(1);   chk("min_wrap_no_carry", b_v, 16'h0500);
    press_min(59); press_hour(4);
    chk("set_0959", b_v, 16'h0959);
    btn_min = 1'b1; btn_hour = 1'b1; step();
    btn_min = 1'b0; btn_hour = 1'b0; step();
    chk("both_from_0959", b_v, 16'h1000);

    // ring and stop with alarm at 07:30
    do_reset();
    set_mode = 1'b1;
    press_hour(7); press_min(30);
    chk("set_0730", b_v, 16'h0730);
    set_mode = 1'b0; alarm_en = 1'b1; a_v = 16'h0729; step();
    chk("no_ring_0729", {15'd0, ring}, 16'd0);
    a_v = 16'h0730; step();
    chk("ring_0730", {15'd0, ring}, 16'd1);
    step();
    chk("ring_hold", {15'd0, ring}, 16'd1);
    stop = 1'b1; step();
    chk("stop_ring", {15'd0, ring}, 16'd0);
    stop = 1'b0; step();
    chk("no_rering_after_stop", {15'd0, ring}, 16'd0);

    // timeout after three ticks, no re-ring while time still matches
    retrigger();
    chk("retrigger_ring", {15'd0, ring}, 16'd1);
    pulse_tick(); chk("tick1_ring", {15'd0, ring}, 16'd1);
    pulse_tick(); chk("tick2_ring", {15'd0, ring}, 16'd1);
    pulse_tick(); chk("tick3_timeout", {15'd0, ring}, 16'd0);
    repeat (4) step();
    chk("no_rering_timeout", {15'd0, ring}, 16'd0);

    // aborts
    retrigger();
    chk("abort_setup1", {15'd0, ring}, 16'd1);
    set_mode = 1'b1; step();
    chk("abort_set_mode", {15'd0, ring}, 16'd0);
    set_mode = 1'b0; step();
    chk("abort_setup2", {15'd0, ring}, 16'd1);
    alarm_en = 1'b0; step();
    chk("abort_alarm_en", {15'd0, ring}, 16'd0);
    alarm_en = 1'b1; step();
    chk("rearm_ring", {15'd0, ring}, 16'd1);

    // snooze request while ringing
    btn_min = 1'b1; step();
`ifdef ALARM_SNOOZE_EN
    chk("snooze_enter", {15'd0, ring}, 16'd0);
`else
    chk("btn_min_ignored", {15'd0, ring}, 16'd1);
`endif
    chk("snooze_no_edit", b_v, 16'h0730);
    btn_min = 1'b0; step();
    pulse_tick();
`ifdef ALARM_SNOOZE_EN
    chk("snooze_tick1", {15'd0, ring}, 16'd0);
`else
    chk("ring_tick1", {15'd0, ring}, 16'd1);
`endif
    pulse_tick();
    chk("snooze_tick2_ring", {15'd0, ring}, 16'd1);
    stop = 1'b1; step(); stop = 1'b0; step();
    chk("stop_after_snooze", {15'd0, ring}, 16'd0);

    // stop during snooze (plain stop without the feature)
    retrigger();
    btn_min = 1'b1; step(); btn_min = 1'b0; step();
    stop = 1'b1; step(); stop = 1'b0; step();
    pulse_tick(); pulse_tick();
    chk("snooze_stop_idle", {15'd0, ring}, 16'd0);

    // async reset mid-ring
    retrigger();
    chk("reset_setup", {15'd0, ring}, 16'd1);
    #2;
    rst_n = 1'b0;
    #2;
    chk("midring_reset_ring", {15'd0, ring}, 16'd0);
    chk("midring_reset_b", b_v, 16'h0000);
    rst_n = 1'b1;
    step();
    chk("post_reset_ring", {15'd0, ring}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
